// File: rtl/writeback_ctrl_pkg.sv
// Shared types and encodings for the register-file write-back sequencer.
// Covers the FSM states, instruction classes, select codes and MIPS opcode/funct values.
package writeback_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_WAIT_ALU = 3'd2,
        ST_WAIT_MEM = 3'd3,
        ST_WRITE    = 3'd4,
        ST_DONE     = 3'd5,
        ST_EXCEPT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_DIRECT = 2'd1,
        CLS_ALU    = 2'd2,
        CLS_LOAD   = 2'd3
    } wb_class_t;

    typedef enum logic [1:0] {
        REGDEST_RT = 2'b00,
        REGDEST_RD = 2'b01,
        REGDEST_RA = 2'b10,
        REGDEST_SP = 2'b11
    } regdest_t;

    typedef enum logic [2:0] {
        WBDATA_ALU = 3'b000,
        WBDATA_MDR = 3'b001,
        WBDATA_PC  = 3'b010,
        WBDATA_HI  = 3'b011,
        WBDATA_LO  = 3'b100,
        WBDATA_IMM = 3'b101
    } wbdata_t;

    typedef struct packed {
        wb_class_t cls;
        regdest_t  regdest;
        wbdata_t   wbdata;
        logic      ovf_chk;
    } decode_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/writeback_ctrl_if.sv
// Instruction/handshake bundle between the control path and the write-back sequencer.
interface writeback_ctrl_if;
    import writeback_ctrl_pkg::*;

    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_overflow;
    logic       mem_ready;
    logic       mem_req;
    regdest_t   seletor_regdest;
    wbdata_t    seletor_wbdata;
    logic       reg_write;
    logic       busy;
    logic       done;
    logic       exception;

    modport master (
        output start, opcode, funct, alu_overflow, mem_ready,
        input  mem_req, seletor_regdest, seletor_wbdata, reg_write, busy, done, exception
    );

    modport slave (
        input  start, opcode, funct, alu_overflow, mem_ready,
        output mem_req, seletor_regdest, seletor_wbdata, reg_write, busy, done, exception
    );
endinterface

// File: rtl/writeback_ctrl_wb_decode.sv
// Combinational instruction classifier: opcode/funct -> write-back class, selects and overflow check.
module wb_decode
    import writeback_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    // classify; anything not listed falls through to the no-write class
    always_comb begin
        dec = '{CLS_NONE, REGDEST_RT, WBDATA_ALU, 1'b0};
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_MFHI:                      dec = '{CLS_DIRECT, REGDEST_RD, WBDATA_HI, 1'b0};
                    FN_MFLO:                      dec = '{CLS_DIRECT, REGDEST_RD, WBDATA_LO, 1'b0};
                    FN_ADD, FN_SUB:               dec = '{CLS_ALU, REGDEST_RD, WBDATA_ALU, 1'b1};
                    FN_ADDU, FN_AND, FN_OR, FN_SLT: dec = '{CLS_ALU, REGDEST_RD, WBDATA_ALU, 1'b0};
                    FN_JR:                        dec = '{CLS_NONE, REGDEST_RT, WBDATA_ALU, 1'b0};
                    default:                      dec = '{CLS_NONE, REGDEST_RT, WBDATA_ALU, 1'b0};
                endcase
            end
            OP_LW, OP_LH, OP_LB:            dec = '{CLS_LOAD, REGDEST_RT, WBDATA_MDR, 1'b0};
            OP_JAL:                         dec = '{CLS_DIRECT, REGDEST_RA, WBDATA_PC, 1'b0};
            OP_LUI:                         dec = '{CLS_DIRECT, REGDEST_RT, WBDATA_IMM, 1'b0};
            OP_ADDI:                        dec = '{CLS_ALU, REGDEST_RT, WBDATA_ALU, 1'b1};
            OP_ADDIU, OP_SLTI, OP_ANDI:     dec = '{CLS_ALU, REGDEST_RT, WBDATA_ALU, 1'b0};
            OP_SW, OP_BEQ, OP_BNE, OP_J:    dec = '{CLS_NONE, REGDEST_RT, WBDATA_ALU, 1'b0};
            default:                        dec = '{CLS_NONE, REGDEST_RT, WBDATA_ALU, 1'b0};
        endcase
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write-back sequencer: classifies an instruction, waits on ALU latency or
// the memory handshake, then issues a single-cycle reg_write, or an exception instead.
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    writeback_ctrl_if.slave   bus
);

    localparam logic [7:0] ALU_LAT_M1 = 8'(ALU_LAT - 1);
    localparam logic [7:0] MEM_TO_M1  = 8'(MEM_TIMEOUT - 1);

    state_t     state_r, next_state_s;
    logic [7:0] cnt_r, cnt_next_s;
    logic [5:0] opcode_r, funct_r;
    logic       ovf_chk_r;
    decode_t    dec_s;

    regdest_t   regdest_r;
    wbdata_t    wbdata_r;
    logic       mem_req_r, reg_write_r, busy_r, done_r, exception_r;

    wb_decode u_decode (
        .opcode (opcode_r),
        .funct  (funct_r),
        .dec    (dec_s)
    );

    // next-state and counter update
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) next_state_s = ST_CLASSIFY;
                else           next_state_s = ST_IDLE;
            end
            ST_CLASSIFY: begin
                case (dec_s.cls)
                    CLS_DIRECT: next_state_s = ST_WRITE;
                    CLS_ALU: begin
                        next_state_s = ST_WAIT_ALU;
                        cnt_next_s   = ALU_LAT_M1;
                    end
                    CLS_LOAD: begin
                        next_state_s = ST_WAIT_MEM;
                        cnt_next_s   = 8'd0;
                    end
                    default: next_state_s = ST_DONE;
                endcase
            end
            ST_WAIT_ALU: begin
                if (cnt_r == 8'd0) begin
                    if (ovf_chk_r && bus.alu_overflow) next_state_s = ST_EXCEPT;
                    else                               next_state_s = ST_WRITE;
                end else begin
                    cnt_next_s = cnt_r - 8'd1;
                end
            end
            ST_WAIT_MEM: begin
                // a ready arriving on the timeout cycle still wins
                if (bus.mem_ready)           next_state_s = ST_WRITE;
                else if (cnt_r >= MEM_TO_M1) next_state_s = ST_EXCEPT;
                else                         cnt_next_s   = cnt_r + 8'd1;
            end
            ST_WRITE:  next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            ST_EXCEPT: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // state, counter and captured instruction fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            opcode_r  <= 6'd0;
            funct_r   <= 6'd0;
            ovf_chk_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            if (state_r == ST_IDLE && bus.start) begin
                opcode_r <= bus.opcode;
                funct_r  <= bus.funct;
            end
            if (state_r == ST_CLASSIFY) ovf_chk_r <= dec_s.ovf_chk;
        end
    end

    // outputs registered from the next state so each lines up with its state cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regdest_r   <= REGDEST_RT;
            wbdata_r    <= WBDATA_ALU;
            mem_req_r   <= 1'b0;
            reg_write_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            exception_r <= 1'b0;
        end else begin
            if (state_r == ST_CLASSIFY) begin
                regdest_r <= dec_s.regdest;
                wbdata_r  <= dec_s.wbdata;
            end else if (next_state_s == ST_IDLE) begin
                regdest_r <= REGDEST_RT;
                wbdata_r  <= WBDATA_ALU;
            end
            mem_req_r   <= (next_state_s == ST_WAIT_MEM);
            reg_write_r <= (next_state_s == ST_WRITE);
            busy_r      <= (next_state_s != ST_IDLE);
            done_r      <= (next_state_s == ST_DONE);
            exception_r <= (next_state_s == ST_EXCEPT);
        end
    end

    assign bus.seletor_regdest = regdest_r;
    assign bus.seletor_wbdata  = wbdata_r;
    assign bus.mem_req         = mem_req_r;
    assign bus.reg_write       = reg_write_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.exception       = exception_r;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Randomized bench for writeback_ctrl: a per-instruction phase-trace model predicts every output each cycle.
module tb_writeback_ctrl;

    localparam int ALU_LAT     = 1;
    localparam int MEM_TIMEOUT = 15;

    localparam int P_CLS  = 0;
    localparam int P_WALU = 1;
    localparam int P_WMEM = 2;
    localparam int P_WR   = 3;
    localparam int P_DONE = 4;
    localparam int P_EXC  = 5;
    localparam int P_IDLE = 6;

    localparam int C_NONE   = 0;
    localparam int C_DIRECT = 1;
    localparam int C_ALU    = 2;
    localparam int C_LOAD   = 3;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                6'h09, 6'h0A, 6'h0C, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h2B};
    logic [5:0] fn_tab [9]  = '{6'h08, 6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A};

    writeback_ctrl_if bus ();

    writeback_ctrl #(.ALU_LAT(ALU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] observed();
        return {bus.busy, bus.mem_req, bus.reg_write, bus.done, bus.exception,
                bus.seletor_regdest, bus.seletor_wbdata};
    endfunction

    function automatic logic [9:0] expected(input int ph, input logic [1:0] rd, input logic [2:0] wb);
        logic [1:0] r;
        logic [2:0] w;
        r = (ph == P_CLS || ph == P_IDLE) ? 2'b00 : rd;
        w = (ph == P_CLS || ph == P_IDLE) ? 3'b000 : wb;
        return {ph != P_IDLE, ph == P_WMEM, ph == P_WR, ph == P_DONE, ph == P_EXC, r, w};
    endfunction

    function automatic string ph_name(input int ph);
        case (ph)
            P_CLS:   return "classify";
            P_WALU:  return "wait_alu";
            P_WMEM:  return "wait_mem";
            P_WR:    return "write";
            P_DONE:  return "done";
            P_EXC:   return "except";
            default: return "idle";
        endcase
    endfunction

    // instruction table from the ISA description of which ops write back and where
    task automatic ref_decode(input logic [5:0] op, input logic [5:0] fn, output int cls,
                              output logic [1:0] rd, output logic [2:0] wb, output bit ovc);
        cls = C_NONE; rd = 2'b00; wb = 3'b000; ovc = 1'b0;
        if (op == 6'h00) begin
            if (fn == 6'h10 || fn == 6'h12) begin
                cls = C_DIRECT; rd = 2'b01; wb = (fn == 6'h10) ? 3'b011 : 3'b100;
            end else if (fn == 6'h20 || fn == 6'h21 || fn == 6'h22 || fn == 6'h24 ||
                         fn == 6'h25 || fn == 6'h2A) begin
                cls = C_ALU; rd = 2'b01; ovc = (fn == 6'h20 || fn == 6'h22);
            end
        end else if (op == 6'h20 || op == 6'h21 || op == 6'h23) begin
            cls = C_LOAD; wb = 3'b001;
        end else if (op == 6'h03) begin
            cls = C_DIRECT; rd = 2'b10; wb = 3'b010;
        end else if (op == 6'h0F) begin
            cls = C_DIRECT; wb = 3'b101;
        end else if (op == 6'h08 || op == 6'h09 || op == 6'h0A || op == 6'h0C) begin
            cls = C_ALU; ovc = (op == 6'h08);
        end
    endtask

    // k_ready: WAIT_MEM cycle (1-based) in which mem_ready rises; ovf_last: overflow in last WAIT_ALU cycle
    task automatic run_txn(input logic [5:0] op, input logic [5:0] fn, input int k_ready, input bit ovf_last);
        int         ph[$];
        int         cls;
        logic [1:0] rd;
        logic [2:0] wb;
        bit         ovc;
        int         wm;
        ref_decode(op, fn, cls, rd, wb, ovc);
        ph.push_back(P_CLS);
        case (cls)
            C_DIRECT: begin ph.push_back(P_WR); ph.push_back(P_DONE); end
            C_ALU: begin
                for (int i = 0; i < ALU_LAT; i++) ph.push_back(P_WALU);
                if (ovc && ovf_last) ph.push_back(P_EXC);
                else begin ph.push_back(P_WR); ph.push_back(P_DONE); end
            end
            C_LOAD: begin
                for (int i = 0; i < ((k_ready <= MEM_TIMEOUT) ? k_ready : MEM_TIMEOUT); i++)
                    ph.push_back(P_WMEM);
                if (k_ready <= MEM_TIMEOUT) begin ph.push_back(P_WR); ph.push_back(P_DONE); end
                else ph.push_back(P_EXC);
            end
            default: ph.push_back(P_DONE);
        endcase
        ph.push_back(P_IDLE);

        bus.start        = 1'b1;
        bus.opcode       = op;
        bus.funct        = fn;
        bus.alu_overflow = 1'($urandom_range(0, 1));
        bus.mem_ready    = 1'($urandom_range(0, 1));
        wm = 0;
        for (int i = 0; i < ph.size(); i++) begin
            @(posedge clk); #1;
            chk(ph_name(ph[i]), {22'd0, observed()}, {22'd0, expected(ph[i], rd, wb)});
            bus.start        = 1'($urandom_range(0, 1));
            bus.opcode       = 6'($urandom);
            bus.funct        = 6'($urandom);
            bus.alu_overflow = 1'($urandom_range(0, 1));
            bus.mem_ready    = 1'($urandom_range(0, 1));
            if (ph[i] == P_WALU && ph[i+1] != P_WALU) bus.alu_overflow = ovf_last;
            if (ph[i] == P_WMEM) begin
                wm++;
                bus.mem_ready = (wm == k_ready);
            end
            if (ph[i] == P_IDLE) bus.start = 1'b0;
        end
    endtask

    initial begin
        int         k;
        logic [5:0] op, fn;
        n_vec = 0;
        n_err = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.opcode       = 6'd0;
        bus.funct        = 6'd0;
        bus.alu_overflow = 1'b0;
        bus.mem_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {22'd0, observed()}, 32'd0);
        reset = 1'b0;

        run_txn(6'h00, 6'h20, 0, 1'b0);   // add, no overflow
        run_txn(6'h08, 6'h00, 0, 1'b1);   // addi overflow -> exception
        run_txn(6'h00, 6'h21, 0, 1'b1);   // addu ignores overflow
        run_txn(6'h23, 6'h00, 4, 1'b0);   // lw, ready in 4th wait cycle
        run_txn(6'h23, 6'h00, 99, 1'b0);  // lw timeout
        run_txn(6'h21, 6'h00, 15, 1'b0);  // ready on the timeout cycle wins
        run_txn(6'h03, 6'h00, 0, 1'b0);   // jal
        run_txn(6'h2B, 6'h00, 0, 1'b0);   // sw
        run_txn(6'h0F, 6'h00, 0, 1'b0);   // lui
        run_txn(6'h00, 6'h12, 0, 1'b0);   // mflo

        // reset in the middle of a load wait
        bus.start  = 1'b1;
        bus.opcode = 6'h23;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mem_req_before_reset", {31'd0, bus.mem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {22'd0, observed()}, 32'd0);
        @(posedge clk); #1;
        chk("held_reset_outputs", {22'd0, observed()}, 32'd0);
        #2;
        reset = 1'b0;
        run_txn(6'h03, 6'h00, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else                           op = op_tab[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            else                           fn = fn_tab[$urandom_range(0, 8)];
            k = $urandom_range(1, 18);
            run_txn(op, fn, k, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
